// File: rtl/gpu_raster_pkg.sv
// Shared raster-pipeline definitions: coordinate/error widths, screen limits and FSM encodings.
// The framebuffer writer reads the same screen limits, so they live here.
`timescale 1ns/1ps
package gpu_raster_pkg;

  localparam int COORD_W_DEFAULT  = 11;
  localparam int ERR_W_DEFAULT    = COORD_W_DEFAULT + 3;
  localparam int SCREEN_W_DEFAULT = 640;
  localparam int SCREEN_H_DEFAULT = 480;

  // Rasterizer FSM, kept as plain constants so older blocks can share the encoding.
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SETUP = 2'd1;
  localparam state_t DRAW  = 2'd2;

endpackage

// File: rtl/bresenham_step.sv
// One integer Bresenham step: from the pre-step error and current pixel, produce the next
// error term and pixel. Purely combinational.
`timescale 1ns/1ps
module bresenham_step #(
  parameter int COORD_W = 11,
  parameter int ERR_W   = COORD_W + 3
) (
  input  logic signed [ERR_W-1:0]   err,
  input  logic signed [ERR_W-1:0]   dx,
  input  logic signed [ERR_W-1:0]   dy,
  input  logic                      sx_neg,
  input  logic                      sy_neg,
  input  logic        [COORD_W-1:0] cur_x,
  input  logic        [COORD_W-1:0] cur_y,
  output logic signed [ERR_W-1:0]   next_err,
  output logic        [COORD_W-1:0] next_x,
  output logic        [COORD_W-1:0] next_y
);

  localparam logic [COORD_W-1:0] ONE = COORD_W'(1);

  logic signed [ERR_W-1:0] e2;

  // NOTE: every output gets a default before the ifs, otherwise a missed branch infers a latch.
  always_comb begin
    e2       = err <<< 1;
    next_err = err;
    next_x   = cur_x;
    next_y   = cur_y;
    // Both tests use the pre-step e2; the two corrections accumulate.
    if (e2 >= dy) begin
      next_err = next_err + dy;
      next_x   = sx_neg ? cur_x - ONE : cur_x + ONE;
    end
    if (e2 <= dx) begin
      next_err = next_err + dx;
      next_y   = sy_neg ? cur_y - ONE : cur_y + ONE;
    end
  end

endmodule

// File: rtl/line_rasterizer.sv
// Turns a vertex pair into a stream of on-screen pixel writes with Bresenham stepping.
// One pixel retires per cycle; off-screen pixels are skipped without being presented.
`timescale 1ns/1ps
module line_rasterizer
  import gpu_raster_pkg::*;
#(
  parameter int COORD_W  = COORD_W_DEFAULT,
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_x0,
  input  logic [15:0] in_y0,
  input  logic [15:0] in_x1,
  input  logic [15:0] in_y1,
  input  logic [15:0] in_color,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_x,
  output logic [15:0] out_y,
  output logic [15:0] out_color,
  output logic        busy,
  output logic        line_done
);

  localparam int ERR_W = COORD_W + 3;

  typedef logic        [COORD_W-1:0] coord_t;
  typedef logic signed [ERR_W-1:0]   err_t;

  // One extra bit so limits up to 2**COORD_W still compare correctly.
  localparam logic [COORD_W:0] X_LIMIT = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0] Y_LIMIT = (COORD_W+1)'(SCREEN_H);

  state_t      state;
  coord_t      x0, y0, x1, y1;
  coord_t      cur_x, cur_y;
  logic [15:0] color;
  err_t        dx, dy, err;
  logic        sx_neg, sy_neg;

  err_t   x0_e, y0_e, x1_e, y1_e;
  err_t   diff_x, diff_y, abs_x, abs_y;
  err_t   next_err;
  coord_t next_x, next_y;
  logic   visible, at_end, retire;

  // Upper port bits beyond COORD_W carry no meaning for this block.
  logic unused_hi;
  assign unused_hi = ^{in_x0[15:COORD_W], in_y0[15:COORD_W],
                       in_x1[15:COORD_W], in_y1[15:COORD_W]};

  always_comb begin
    x0_e   = {{(ERR_W-COORD_W){1'b0}}, x0};
    y0_e   = {{(ERR_W-COORD_W){1'b0}}, y0};
    x1_e   = {{(ERR_W-COORD_W){1'b0}}, x1};
    y1_e   = {{(ERR_W-COORD_W){1'b0}}, y1};
    diff_x = x1_e - x0_e;
    diff_y = y1_e - y0_e;
    abs_x  = diff_x[ERR_W-1] ? -diff_x : diff_x;
    abs_y  = diff_y[ERR_W-1] ? -diff_y : diff_y;
  end

  bresenham_step #(
    .COORD_W (COORD_W),
    .ERR_W   (ERR_W)
  ) u_step (
    .err      (err),
    .dx       (dx),
    .dy       (dy),
    .sx_neg   (sx_neg),
    .sy_neg   (sy_neg),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .next_err (next_err),
    .next_x   (next_x),
    .next_y   (next_y)
  );

  always_comb begin
    visible = ({1'b0, cur_x} < X_LIMIT) && ({1'b0, cur_y} < Y_LIMIT);
    at_end  = (cur_x == x1) && (cur_y == y1);
    // A clipped pixel never waits on downstream.
    retire  = (state == DRAW) && (!visible || out_ready);
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == SETUP) || (state == DRAW);
  assign out_valid = (state == DRAW) && visible;
  assign line_done = retire && at_end;
  assign out_x     = {{(16-COORD_W){1'b0}}, cur_x};
  assign out_y     = {{(16-COORD_W){1'b0}}, cur_y};
  assign out_color = color;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      x0     <= '0;
      y0     <= '0;
      x1     <= '0;
      y1     <= '0;
      cur_x  <= '0;
      cur_y  <= '0;
      color  <= '0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x0    <= in_x0[COORD_W-1:0];
            y0    <= in_y0[COORD_W-1:0];
            x1    <= in_x1[COORD_W-1:0];
            y1    <= in_y1[COORD_W-1:0];
            color <= in_color;
            state <= SETUP;
          end
        end
        SETUP: begin
          dx     <= abs_x;
          dy     <= -abs_y;
          err    <= abs_x - abs_y;
          sx_neg <= !(x0 < x1);
          sy_neg <= !(y0 < y1);
          cur_x  <= x0;
          cur_y  <= y0;
          state  <= DRAW;
        end
        DRAW: begin
          if (retire) begin
            if (at_end) begin
              state <= IDLE;
            end else begin
              err   <= next_err;
              cur_x <= next_x;
              cur_y <= next_y;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_rasterizer.sv
// Directed bench for line_rasterizer: expected pixels are queued by the stimulus and
// popped by an independent monitor whenever the DUT hands a pixel downstream.
`timescale 1ns/1ps
module tb_line_rasterizer;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] c;
    logic        last;
  } pix_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x0 = '0, in_y0 = '0, in_x1 = '0, in_y1 = '0, in_color = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_x, out_y, out_color;
  logic        busy;
  logic        line_done;

  line_rasterizer dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x0     (in_x0),
    .in_y0     (in_y0),
    .in_x1     (in_x1),
    .in_y1     (in_y1),
    .in_color  (in_color),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y     (out_y),
    .out_color (out_color),
    .busy      (busy),
    .line_done (line_done)
  );

  always #5 clock = ~clock;

  pix_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   hs_cnt = 0, hs_cyc = 0, prev_hs_cyc = 0;
  int   done_cnt = 0, exp_done = 0, done_cyc = 0;
  int   first_cyc = 0, last_pix_cyc = 0, rise_cyc = 0;
  logic armed = 1'b0, prev_ready = 1'b1, prev_stall = 1'b0;
  logic [15:0] held_x = '0, held_y = '0, held_c = '0;
  logic rand_ready = 1'b0;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int x, input int y, input logic [15:0] c, input logic last);
    pix_t p;
    p.x = 16'(x);
    p.y = 16'(y);
    p.c = c;
    p.last = last;
    exp_q.push_back(p);
  endtask

  // Monitor: samples on the falling edge, well away from the active edge.
  always @(negedge clock) begin
    if (reset_n) begin
      if (prev_stall) begin
        check("stall_valid_held", 32'(out_valid), 32'd1);
        check("stall_x_held", 32'(out_x), 32'(held_x));
        check("stall_y_held", 32'(out_y), 32'(held_y));
        check("stall_color_held", 32'(out_color), 32'(held_c));
      end
      if (in_valid && in_ready) begin
        prev_hs_cyc = hs_cyc;
        hs_cyc = cyc;
        hs_cnt++;
        armed = 1'b1;
      end
      if (in_ready && !prev_ready) rise_cyc = cyc;
      if (out_valid && armed) begin
        first_cyc = cyc;
        armed = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_pixel: got (%0d,%0d) expected none", out_x, out_y);
        end else begin
          pix_t e;
          e = exp_q.pop_front();
          check("pixel_x", 32'(out_x), 32'(e.x));
          check("pixel_y", 32'(out_y), 32'(e.y));
          check("pixel_color", 32'(out_color), 32'(e.c));
          check("pixel_line_done", 32'(line_done), 32'(e.last));
        end
        last_pix_cyc = cyc;
      end
      if (line_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      held_x = out_x;
      held_y = out_y;
      held_c = out_color;
    end else begin
      prev_stall = 1'b0;
      armed = 1'b0;
    end
    prev_ready = in_ready;
  end

  initial forever begin
    @(posedge clock);
    #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  task automatic send(input int ax0, input int ay0, input int ax1, input int ay1,
                      input logic [15:0] c, input bit hold);
    int start;
    int n;
    start = hs_cnt;
    n = 0;
    @(posedge clock);
    #1;
    in_x0 = 16'(ax0);
    in_y0 = 16'(ay0);
    in_x1 = 16'(ax1);
    in_y1 = 16'(ay1);
    in_color = c;
    in_valid = 1'b1;
    while (hs_cnt == start && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("handshake_seen", 32'(hs_cnt - start), 32'd1);
    if (!hold) begin
      @(posedge clock);
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !in_ready || done_cnt != exp_done) && n < 500) begin
      @(negedge clock);
      #1;
      n++;
    end
    check({name, "_finished_in_budget"}, 32'(n < 500), 32'd1);
    check({name, "_line_done_count"}, 32'(done_cnt), 32'(exp_done));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int d0;
    int start;
    int n;

    #3;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_line_done", 32'(line_done), 32'd0);
    check("rst_out_x", 32'(out_x), 32'd0);
    check("rst_out_y", 32'(out_y), 32'd0);
    check("rst_out_color", 32'(out_color), 32'd0);
    #19;
    reset_n = 1'b1;

    // Horizontal line, full throughput.
    push(0, 0, 16'hA5A5, 1'b0);
    push(1, 0, 16'hA5A5, 1'b0);
    push(2, 0, 16'hA5A5, 1'b0);
    push(3, 0, 16'hA5A5, 1'b1);
    exp_done++;
    send(0, 0, 3, 0, 16'hA5A5, 1'b0);
    wait_idle("horiz");
    check("horiz_first_pixel_cycle", 32'(first_cyc - hs_cyc), 32'd2);
    check("horiz_line_done_cycle", 32'(done_cyc - hs_cyc), 32'd5);
    check("horiz_in_ready_cycle", 32'(rise_cyc - hs_cyc), 32'd6);

    // Steep line and its reverse.
    push(0, 0, 16'h1234, 1'b0);
    push(0, 1, 16'h1234, 1'b0);
    push(1, 2, 16'h1234, 1'b0);
    push(1, 3, 16'h1234, 1'b1);
    exp_done++;
    send(0, 0, 1, 3, 16'h1234, 1'b0);
    wait_idle("steep");
    push(1, 3, 16'h4321, 1'b0);
    push(1, 2, 16'h4321, 1'b0);
    push(0, 1, 16'h4321, 1'b0);
    push(0, 0, 16'h4321, 1'b1);
    exp_done++;
    send(1, 3, 0, 0, 16'h4321, 1'b0);
    wait_idle("steep_rev");

    // Random backpressure; the monitor also checks outputs hold while stalled.
    rand_ready = 1'b1;
    push(5, 5, 16'h0F0F, 1'b0);
    push(6, 6, 16'h0F0F, 1'b0);
    push(7, 6, 16'h0F0F, 1'b0);
    push(8, 7, 16'h0F0F, 1'b1);
    exp_done++;
    send(5, 5, 8, 7, 16'h0F0F, 1'b0);
    wait_idle("backpressure");
    @(posedge clock);
    #1;
    rand_ready = 1'b0;
    out_ready = 1'b1;

    // Right-edge clipping: 640 and 641 are skipped silently.
    push(638, 5, 16'h7777, 1'b0);
    push(639, 5, 16'h7777, 1'b0);
    exp_done++;
    send(638, 5, 641, 5, 16'h7777, 1'b0);
    wait_idle("clip");
    check("clip_done_after_last_visible", 32'(done_cyc - last_pix_cyc), 32'd2);
    check("clip_done_cycle", 32'(done_cyc - hs_cyc), 32'd5);

    // Single point, request held: second copy is accepted only once IDLE again.
    push(10, 20, 16'hC0DE, 1'b1);
    push(10, 20, 16'hC0DE, 1'b1);
    exp_done += 2;
    start = hs_cnt;
    send(10, 20, 10, 20, 16'hC0DE, 1'b1);
    n = 0;
    while (hs_cnt < start + 2 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    wait_idle("point");
    check("point_handshakes", 32'(hs_cnt - start), 32'd2);
    check("point_rehandshake_gap", 32'(hs_cyc - prev_hs_cyc), 32'd3);
    check("point_done_with_pixel", 32'(done_cyc - last_pix_cyc), 32'd0);
    check("point_done_cycle", 32'(done_cyc - hs_cyc), 32'd2);

    // Reset while pixel 40 of a long line is presented.
    for (int i = 0; i < 40; i++) push(i, 0, 16'hBEEF, 1'b0);
    d0 = done_cnt;
    send(0, 0, 100, 0, 16'hBEEF, 1'b0);
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("abort_reached_pixel_40", 32'(exp_q.size()), 32'd0);
    @(posedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_line_done", 32'(line_done), 32'd0);
    check("abort_out_x", 32'(out_x), 32'd0);
    check("abort_out_color", 32'(out_color), 32'd0);
    @(negedge clock);
    @(negedge clock);
    #1;
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    check("abort_no_line_done", 32'(done_cnt - d0), 32'd0);

    push(2, 1, 16'h00FF, 1'b0);
    push(3, 1, 16'h00FF, 1'b1);
    exp_done++;
    send(2, 1, 3, 1, 16'h00FF, 1'b0);
    wait_idle("after_reset");
    check("after_reset_first_pixel_cycle", 32'(first_cyc - hs_cyc), 32'd2);
    check("after_reset_done_cycle", 32'(done_cyc - hs_cyc), 32'd3);

    repeat (3) @(negedge clock);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
